// File: rtl/ram_wr_ctrl.sv
// RAM write controller: stores one ROW x CLO row-major frame, then hands it to the column reader.
// Optional macro RAM_WR_CTRL_SOF_EN adds in_sof frame alignment and the sof_err pulse.
module ram_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROW        = 64,
    parameter int unsigned CLO        = 2400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef RAM_WR_CTRL_SOF_EN
    input  logic                  in_sof,
    output logic                  sof_err,
`endif
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_command,
    input  logic                  rd_finish,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW * CLO - 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_RD} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  cmd_pend;
    logic                  accept;

    always_comb accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_pend   <= 1'b0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_command <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
`ifdef RAM_WR_CTRL_SOF_EN
            sof_err    <= 1'b0;
`endif
        end else begin
            wr_en      <= 1'b0;
            rd_command <= 1'b0;
`ifdef RAM_WR_CTRL_SOF_EN
            sof_err    <= 1'b0;
`endif
            case (state)
                IDLE, WRITE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
`ifdef RAM_WR_CTRL_SOF_EN
                        // Early sof restarts the frame at address 0; a word at address 0 without sof is dropped.
                        if (in_sof && cnt != '0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= '0;
                            wr_data <= in_data;
                            cnt     <= ADDR_WIDTH'(1);
                            sof_err <= 1'b1;
                        end else if (!in_sof && cnt == '0) begin
                            sof_err <= 1'b1;
                        end else
`endif
                        begin
                            wr_en   <= 1'b1;
                            wr_addr <= cnt;
                            wr_data <= in_data;
                            busy    <= 1'b1;
                            if (cnt == LAST_ADDR) begin
                                cnt      <= '0;
                                state    <= WAIT_RD;
                                in_ready <= 1'b0;
                                cmd_pend <= 1'b1;
                            end else begin
                                cnt   <= cnt + ADDR_WIDTH'(1);
                                state <= WRITE;
                            end
                        end
                    end
                end
                WAIT_RD: begin
                    in_ready <= 1'b0;
                    // The command waits one cycle so the final RAM write lands before the reader starts.
                    if (cmd_pend) begin
                        cmd_pend   <= 1'b0;
                        rd_command <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end else if (rd_finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Randomized self-checking bench for ram_wr_ctrl against an event-schedule model of frame handling.
module tb_ram_wr_ctrl;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned NC = 3;
    localparam int unsigned NW = NR * NC;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          rd_finish = 1'b0;
    logic          in_ready, wr_en, rd_command, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [15:0]   frame_cnt;

    logic          in_valid1  = 1'b0;
    logic [7:0]    in_data1   = 8'h5A;
    logic          rd_finish1 = 1'b0;
    logic          in_ready1, wr_en1, rd_command1, busy1;
    logic [3:0]    wr_addr1;
    logic [7:0]    wr_data1;
    logic [15:0]   frame_cnt1;

`ifdef RAM_WR_CTRL_SOF_EN
    logic in_sof  = 1'b0;
    logic in_sof1 = 1'b1;
    logic sof_err, sof_err1;
    bit   sof_force = 1'b0;
    bit   sof_val   = 1'b0;
    int unsigned n_err_obs = 0;
`endif

    ram_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(NR), .CLO(NC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef RAM_WR_CTRL_SOF_EN
        .in_sof(in_sof), .sof_err(sof_err),
`endif
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_command(rd_command), .rd_finish(rd_finish), .busy(busy), .frame_cnt(frame_cnt)
    );

    ram_wr_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ROW(1), .CLO(1)) u_one (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
`ifdef RAM_WR_CTRL_SOF_EN
        .in_sof(in_sof1), .sof_err(sof_err1),
`endif
        .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_command(rd_command1), .rd_finish(rd_finish1), .busy(busy1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_wr_obs = 0;
    int unsigned n_cmd_obs = 0;

    // Reference model: edge index, word position in frame, and scheduled frame events.
    int unsigned e_cnt, m_cnt, m_last_edge, m_rel_edge;
    bit          m_ready, m_full, m_rel, m_boot;
    logic [15:0] m_frames;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got 0x%0h expected 0x%0h", tag, e_cnt, got, exp);
        end
    endtask

    task automatic model_init();
        e_cnt = 0; m_cnt = 0; m_last_edge = 0; m_rel_edge = 0;
        m_ready = 1'b0; m_full = 1'b0; m_rel = 1'b0; m_boot = 1'b1;
        m_frames = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; rd_finish = 1'b0; in_valid1 = 1'b0; rd_finish1 = 1'b0;
        #1;
        check_val("rst in_ready",   64'(in_ready),   64'(0));
        check_val("rst wr_en",      64'(wr_en),      64'(0));
        check_val("rst wr_addr",    64'(wr_addr),    64'(0));
        check_val("rst wr_data",    64'(wr_data),    64'(0));
        check_val("rst rd_command", 64'(rd_command), 64'(0));
        check_val("rst frame_cnt",  64'(frame_cnt),  64'(0));
        check_val("rst busy",       64'(busy),       64'(0));
        check_val("rst one ready",  64'(in_ready1),  64'(0));
        check_val("rst one busy",   64'(busy1),      64'(0));
        check_val("rst one fcnt",   64'(frame_cnt1), 64'(0));
`ifdef RAM_WR_CTRL_SOF_EN
        check_val("rst sof_err",    64'(sof_err),    64'(0));
`endif
        repeat (2) begin
            @(negedge clk);
            check_val("rst hold rd_command", 64'(rd_command), 64'(0));
        end
        rst = 1'b0;
        model_init();
    endtask

    // One clock: drive inputs, advance the model at the edge, compare outputs on the falling edge.
    task automatic step(input bit v, input bit fin, input logic [DW-1:0] d);
        bit acc, x_wr, x_cmd, x_busy;
        int unsigned x_addr;
`ifdef RAM_WR_CTRL_SOF_EN
        bit sof, x_err;
        sof = sof_force ? sof_val : (m_cnt == 0);
        in_sof = sof;
        x_err = 1'b0;
`endif
        in_valid = v; in_data = d; rd_finish = fin;
        x_wr = 1'b0; x_cmd = 1'b0; x_addr = 0;
        @(posedge clk);
        e_cnt++;
        acc = v && m_ready;
        if (m_full && !m_rel && e_cnt == m_last_edge + 1) begin
            x_cmd = 1'b1;
            m_frames = m_frames + 16'd1;
        end
        if (m_rel && e_cnt == m_rel_edge + 1) begin
            m_full = 1'b0; m_rel = 1'b0; m_ready = 1'b1;
        end
        if (m_full && !m_rel && fin && e_cnt >= m_last_edge + 2) begin
            m_rel = 1'b1; m_rel_edge = e_cnt;
        end
        if (m_boot) begin
            m_boot = 1'b0; m_ready = 1'b1;
        end
        if (acc) begin
`ifdef RAM_WR_CTRL_SOF_EN
            if (sof && m_cnt != 0) begin
                x_err = 1'b1; x_wr = 1'b1; x_addr = 0; m_cnt = 1;
            end else if (!sof && m_cnt == 0) begin
                x_err = 1'b1;
            end else
`endif
            begin
                x_wr = 1'b1; x_addr = m_cnt;
                if (m_cnt == NW - 1) begin
                    m_cnt = 0; m_full = 1'b1; m_last_edge = e_cnt; m_ready = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
        end
        x_busy = !(m_cnt == 0 && (!m_full || m_rel));
        @(negedge clk);
        check_val("in_ready",   64'(in_ready),   64'(m_ready));
        check_val("wr_en",      64'(wr_en),      64'(x_wr));
        if (x_wr) begin
            check_val("wr_addr", 64'(wr_addr), 64'(x_addr));
            check_val("wr_data", 64'(wr_data), 64'(d));
        end
        check_val("rd_command", 64'(rd_command), 64'(x_cmd));
        check_val("frame_cnt",  64'(frame_cnt),  64'(m_frames));
        check_val("busy",       64'(busy),       64'(x_busy));
`ifdef RAM_WR_CTRL_SOF_EN
        check_val("sof_err",    64'(sof_err),    64'(x_err));
        if (sof_err) n_err_obs++;
`endif
        if (wr_en) n_wr_obs++;
        if (rd_command) n_cmd_obs++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, base_cmd;
        logic [15:0] exp1;
        bit seen;
        model_init();
        #2;
        do_reset();

        // Directed frame with continuous valid.
        step(1'b0, 1'b0, $urandom);
        for (int i = 0; i < int'(NW); i++) step(1'b1, 1'b0, DW'(32'h100 + i));
        check_val("ready low after last", 64'(in_ready), 64'(0));
        check_val("no cmd before last write done", 64'(n_cmd_obs), 64'(0));

        // Held in WAIT_RD with valid asserted.
        base = n_wr_obs;
        repeat (50) step(1'b1, 1'b0, $urandom);
        check_val("hold writes", 64'(n_wr_obs - base), 64'(0));
        check_val("hold cmd count", 64'(n_cmd_obs), 64'(1));
        check_val("frame_cnt after frame 1", 64'(frame_cnt), 64'(1));
        step(1'b0, 1'b1, $urandom);
        step(1'b1, 1'b0, $urandom);
        check_val("ready two cycles after finish", 64'(in_ready), 64'(1));
        step(1'b1, 1'b0, $urandom);
        check_val("restart addr", 64'(wr_addr), 64'(0));

        // Reset after the 7th accept of a frame.
        repeat (6) step(1'b1, 1'b0, $urandom);
        base_cmd = n_cmd_obs;
        do_reset();
        check_val("no cmd across reset", 64'(n_cmd_obs - base_cmd), 64'(0));
        repeat (NW + 4) step(1'b1, 1'b0, $urandom);
        check_val("frame_cnt after fresh frame", 64'(frame_cnt), 64'(1));

        // Random valid gaps and random finish pulses across two frames.
        do_reset();
        base = n_wr_obs;
        for (int k = 0; k < 3000 && m_frames < 16'd2; k++)
            step($urandom_range(0, 99) >= 40, $urandom_range(0, 99) < 30, $urandom);
        check_val("random frames done", 64'(m_frames), 64'(2));
        check_val("random write count", 64'(n_wr_obs - base), 64'(2 * NW));
        check_val("random frame_cnt", 64'(frame_cnt), 64'(2));

`ifdef RAM_WR_CTRL_SOF_EN
        // Early sof abandons the partial frame; a leading word without sof is dropped.
        do_reset();
        step(1'b0, 1'b0, $urandom);
        sof_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sof_val = (i == 0);
            step(1'b1, 1'b0, $urandom);
        end
        base_cmd = n_cmd_obs;
        sof_val = 1'b1;
        step(1'b1, 1'b0, $urandom);
        check_val("sof restart err", 64'(sof_err), 64'(1));
        check_val("sof restart addr", 64'(wr_addr), 64'(0));
        sof_val = 1'b0;
        repeat (NW - 1) step(1'b1, 1'b0, $urandom);
        repeat (3) step(1'b0, 1'b0, $urandom);
        check_val("sof one cmd", 64'(n_cmd_obs - base_cmd), 64'(1));
        check_val("sof frame_cnt", 64'(frame_cnt), 64'(1));
        step(1'b0, 1'b1, $urandom);
        step(1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        check_val("nosof lead not written", 64'(wr_en), 64'(0));
        check_val("nosof lead err", 64'(sof_err), 64'(1));
        sof_val = 1'b1;
        step(1'b1, 1'b0, $urandom);
        check_val("after drop addr", 64'(wr_addr), 64'(0));
        sof_force = 1'b0;
`endif

        // frame_cnt wrap on the single-word instance, preloaded near the top.
        do_reset();
        @(negedge clk);
        force u_one.frame_cnt = 16'hFFFD;
        @(negedge clk);
        release u_one.frame_cnt;
        exp1 = 16'hFFFD;
        in_valid1 = 1'b1; rd_finish1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (wr_en1) begin
                    check_val("one wr_addr", 64'(wr_addr1), 64'(0));
                    check_val("one wr_data", 64'(wr_data1), 64'(in_data1));
                end
`ifdef RAM_WR_CTRL_SOF_EN
                check_val("one sof_err", 64'(sof_err1), 64'(0));
`endif
                if (rd_command1) begin
                    seen = 1'b1;
                    exp1 = exp1 + 16'd1;
                    check_val("one frame_cnt", 64'(frame_cnt1), 64'(exp1));
                end
            end
            if (!seen) check_val("one cmd timeout", 64'(0), 64'(1));
        end
        check_val("wrap to zero", 64'(frame_cnt1), 64'(0));
        in_valid1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_wr_ctrl.md
Name: ram_wr_ctrl

Overview:
RAM write controller for the matrix-transpose datapath. It accepts a row-major pixel stream over a valid/ready handshake and writes one frame of ROW*CLO words to sequential RAM addresses 0..ROW*CLO-1. When the frame is complete, it issues a single-cycle rd_command to the column-order read controller. It then holds off new input until that controller reports rd_finish, so a frame is never overwritten while it is being read.

Parameters:
ADDR_WIDTH, 18, RAM address width; ROW*CLO <= 2**ADDR_WIDTH is required.
DATA_WIDTH, 32, data word width.
ROW, 64, rows per frame.
CLO, 2400, columns per frame (words per row).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream word valid
in_data  input  DATA_WIDTH  upstream word
in_ready  output  1  controller can accept a word this cycle
wr_en  output  1  RAM write enable
wr_addr  output  ADDR_WIDTH  RAM write address
wr_data  output  DATA_WIDTH  RAM write data
rd_command  output  1  one-cycle pulse: frame stored, start reading
rd_finish  input  1  read controller has reached address ROW*CLO-1
busy  output  1  high when state != IDLE
frame_cnt  output  16  count of completed frames; wraps at 65535->0

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_command=0, frame_cnt=0, state=IDLE, addr counter=0.
- Reset mid-frame discards the partial frame. No rd_command is issued.
- All outputs are registered.
- in_ready goes to 1 on the first clk edge after reset release.
- Handshake: a word is accepted when in_valid && in_ready on a rising edge.
- in_data is ignored when in_ready=0.
- Write latency: an accept at edge N gives wr_en=1, wr_addr=cnt, wr_data=in_data during cycle N+1.
- wr_en=0 in any cycle that follows an edge with no accept.
- Address counter:
  - Increments by 1 per accept.
  - Row-major, so the address of (r,c) is r*CLO+c.
  - Returns to 0 after the last word (cnt=ROW*CLO-1).
  - Compare against ROW*CLO-1 at full ADDR_WIDTH.
- States:
  - IDLE: in_ready=1. The first accept moves to WRITE.
  - WRITE: in_ready=1. The accept of the last word moves to WAIT_RD, and in_ready=0 from that edge onward, so no extra word is accepted.
  - WAIT_RD:
    - rd_command=1 for exactly one cycle, the cycle after the last wr_en, so the final RAM write has completed first.
    - frame_cnt increments on the same edge.
    - rd_finish=1 (sampled on or after the rd_command cycle) moves to IDLE. in_ready=1 on the following cycle.
- rd_finish is ignored in IDLE and WRITE.
- rd_finish in the same cycle as rd_command is honoured.
- A single-word frame (ROW=CLO=1) goes IDLE -> WAIT_RD directly.
- in_valid held low mid-frame: the controller stays in WRITE indefinitely and the address is retained.

Optional Feature:
Macro: RAM_WR_CTRL_SOF_EN.
- With the macro:
  - Adds input in_sof (1 bit, start of frame, qualified by the handshake) and output sof_err (1-cycle pulse, reset 0).
  - An accept with in_sof=1 while cnt!=0: the partial frame is abandoned. The word is written at address 0, cnt becomes 1, sof_err pulses in cycle N+1, and there is no rd_command for the abandoned frame.
  - An accept with cnt=0 and in_sof=0: the word is consumed but not written (wr_en stays 0), cnt stays 0, state is unchanged, and sof_err pulses.
- Without the macro: in_sof and sof_err do not exist, and frame alignment depends only on the word count.

Test Plan:
- ROW=4, CLO=3. Stream 12 words 0x100..0x10B with continuous valid. Required:
  - wr_addr 0..11 with matching data, one cycle after each accept.
  - in_ready low after the 12th accept.
  - rd_command high exactly one cycle, the cycle after wr_addr=11.
  - frame_cnt=1.
- Frame 1 done and held in WAIT_RD with rd_finish=0 for 50 cycles, in_valid=1 throughout. Required: no accepts and wr_en=0. Then pulse rd_finish=1 -> in_ready=1 two cycles later, and the next word goes to wr_addr=0.
- Random in_valid gaps (~40% idle) across 2 frames. Required: 24 writes with contiguous addresses 0..11 twice, no duplicates, and frame_cnt=2.
- Assert rst after the 7th accept. Required: all outputs return to reset values, with no rd_command. A fresh 12-word frame then completes normally with frame_cnt=1.
- Set frame_cnt to 65535 via repeated frames (ROW=CLO=1). Required: the next rd_command wraps it to 0.
- With RAM_WR_CTRL_SOF_EN, send sof at word 5 of a frame. Required: sof_err pulses, that word lands at address 0, and 12 further words give exactly one rd_command. Also send a leading word without sof: it is not written, sof_err pulses, and cnt stays 0.
